// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: registered next-PC generator for the fetch stage.
//
// Holds the architectural fetch PC and presents it to the Icache. On each
// accepted request, the PC advances by a stride that decode supplies. Redirect
// channels can override the sequential stride, and the lowest channel index
// wins. A redirect that arrives while the stage is stalled is held in a
// pending register until the stall releases, so it is never lost.
//
// Handshake: a request transfers on a cycle where fetch_valid & fetch_ready
// are both high and stall is low. While fetch_valid & ~fetch_ready, fetch_pc
// is held stable. A redirect taken in that situation abandons the request,
// and fetch_kill pulses in the same cycle.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   stall          freezes the PC and defers redirects
//   redir_valid    per-channel redirect pulse (bit 0 = highest priority)
//   redir_pc       per-channel target, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   decode_step    stride code 0..4 => +0,+2,+4,+6,+8; 5..7 are illegal
//   fetch_ready    Icache accepts the request
//   fetch_valid    request valid
//   fetch_pc       request address (register output)
//   fetch_kill     outstanding unaccepted request abandoned (combinational)
//   redir_pending  a deferred redirect is held
//   step_err       illegal decode_step on an accepted request (combinational)
module fetch_pc_gen #(
  parameter int                     ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  START_PC   = '0,
  parameter int                     NUM_REDIR  = 2,
  parameter int                     PLUS_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic [NUM_REDIR-1:0]            redir_valid,
  input  logic [NUM_REDIR*ADDR_WIDTH-1:0] redir_pc,
  input  logic [PLUS_WIDTH-1:0]           decode_step,
  input  logic                            fetch_ready,
  output logic                            fetch_valid,
  output logic [ADDR_WIDTH-1:0]           fetch_pc,
  output logic                            fetch_kill,
  output logic                            redir_pending,
  output logic                            step_err
);

  localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic [IDX_W-1:0]       pend_idx_q, pend_idx_d;

  logic                   redir_any;
  logic [IDX_W-1:0]       sel_idx;
  logic [ADDR_WIDTH-1:0]  sel_pc;
  logic                   step_legal;
  logic [ADDR_WIDTH-1:0]  stride;
  logic                   fire;
  logic                   new_wins;

  // Redirect arbitration. Scanning downward lets the lowest asserted index
  // write last. Bit 0 of the target is forced low for 2-byte alignment.
  always_comb begin
    redir_any = 1'b0;
    sel_idx   = '0;
    sel_pc    = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_pc    = redir_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    sel_pc[0] = 1'b0;
  end

  assign step_legal = (decode_step <= PLUS_WIDTH'(4));
  assign stride     = ADDR_WIDTH'(decode_step) << 1;
  assign fire       = fetch_valid & fetch_ready & ~stall;
  // A fresh redirect may replace the held one only at equal or higher priority.
  assign new_wins   = redir_any & (sel_idx <= pend_idx_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_idx_d = pend_idx_q;
    fetch_kill = 1'b0;
    step_err   = 1'b0;
    unique case (state_q)
      BOOT: begin
        // A redirect during BOOT behaves like a stalled redirect in RUN.
        if (redir_any) begin
          pend_pc_d  = sel_pc;
          pend_idx_d = sel_idx;
          state_d    = HOLD;
        end else begin
          state_d    = RUN;
        end
      end
      RUN: begin
        if (redir_any) begin
          if (stall) begin
            pend_pc_d  = sel_pc;
            pend_idx_d = sel_idx;
            state_d    = HOLD;
          end else begin
            pc_d       = sel_pc;
            fetch_kill = ~fetch_ready;
          end
        end else if (fire) begin
          if (step_legal) pc_d = pc_q + stride;
          else            step_err = 1'b1;
        end
      end
      HOLD: begin
        if (stall) begin
          if (new_wins) begin
            pend_pc_d  = sel_pc;
            pend_idx_d = sel_idx;
          end
        end else begin
          pc_d       = new_wins ? sel_pc : pend_pc_q;
          pend_pc_d  = '0;
          pend_idx_d = '0;
          fetch_kill = ~fetch_ready;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= START_PC;
      pend_pc_q  <= '0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  assign fetch_valid   = (state_q != BOOT);
  assign fetch_pc      = pc_q;
  assign redir_pending = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  localparam int          AW    = 32;
  localparam logic [31:0] START = 32'h0000_0100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          stall;
  logic [1:0]    redir_valid;
  logic [63:0]   redir_pc;
  logic [2:0]    decode_step;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic          fetch_kill;
  logic          redir_pending;
  logic          step_err;

  fetch_pc_gen #(
    .ADDR_WIDTH (AW),
    .START_PC   (START),
    .NUM_REDIR  (2),
    .PLUS_WIDTH (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .decode_step   (decode_step),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_kill    (fetch_kill),
    .redir_pending (redir_pending),
    .step_err      (step_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    redir_valid = v;
    redir_pc    = {pc1, pc0};
    #1;
  endtask

  task automatic no_redir();
    redir_valid = 2'b00;
    redir_pc    = '0;
    #1;
  endtask

  initial begin
    stall = 1'b0; redir_valid = '0; redir_pc = '0;
    decode_step = 3'd0; fetch_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_pc",      fetch_pc,      START);
    check("rst_valid",   32'(fetch_valid),   32'd0);
    check("rst_pending", 32'(redir_pending), 32'd0);
    check("rst_kill",    32'(fetch_kill),    32'd0);
    check("rst_err",     32'(step_err),      32'd0);

    // sequential +4 after boot
    rst = 1'b0; fetch_ready = 1'b1; decode_step = 3'd2;
    tick();
    check("boot_valid", 32'(fetch_valid), 32'd1);
    check("seq0", fetch_pc, 32'h100);
    tick(); check("seq1", fetch_pc, 32'h104);
    tick(); check("seq2", fetch_pc, 32'h108);
    tick(); check("seq3", fetch_pc, 32'h10C);

    // both channels at once, unstalled: channel 0 wins
    redir(2'b11, 32'h2000, 32'h3000);
    check("dual_kill", 32'(fetch_kill), 32'd0);
    tick(); no_redir();
    check("dual_pc",      fetch_pc,               32'h2000);
    check("dual_pending", 32'(redir_pending),     32'd0);
    tick(); check("post_dual_seq", fetch_pc, 32'h2004);

    // stalled: ch1 captured, ch0 two cycles later overwrites it
    stall = 1'b1;
    redir(2'b10, 32'h0, 32'h3000);
    tick(); no_redir();
    check("hold_pending1", 32'(redir_pending), 32'd1);
    check("hold_pc1",      fetch_pc,           32'h2004);
    tick();
    check("hold_pc2", fetch_pc, 32'h2004);
    redir(2'b01, 32'h2000, 32'h0);
    tick(); no_redir();
    check("hold_pending3", 32'(redir_pending), 32'd1);
    stall = 1'b0;
    tick();
    check("hold_release_pc",      fetch_pc,           32'h2000);
    check("hold_release_pending", 32'(redir_pending), 32'd0);

    // stalled: pending ch0 is not displaced by a later ch1
    stall = 1'b1;
    redir(2'b01, 32'h600, 32'h0);
    tick();
    redir(2'b10, 32'h0, 32'h700);
    tick(); no_redir();
    stall = 1'b0;
    tick();
    check("drop_low_pri", fetch_pc, 32'h600);

    // stable PC under backpressure, redirect kills, odd target aligned
    redir(2'b01, 32'h40, 32'h0);
    tick(); no_redir();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stable", fetch_pc, 32'h40);
    end
    redir(2'b01, 32'h81, 32'h0);
    check("bp_kill", 32'(fetch_kill), 32'd1);
    tick(); no_redir();
    check("bp_aligned_pc", fetch_pc, 32'h80);
    check("bp_kill_clear", 32'(fetch_kill), 32'd0);

    // wrap-around, then illegal stride
    fetch_ready = 1'b1;
    redir(2'b01, 32'hFFFF_FFFC, 32'h0);
    tick(); no_redir();
    check("wrap_start", fetch_pc, 32'hFFFF_FFFC);
    decode_step = 3'd4;
    tick();
    check("wrap_pc", fetch_pc, 32'h0000_0004);
    decode_step = 3'd6; #1;
    check("step_err_on", 32'(step_err), 32'd1);
    tick();
    check("step_err_hold", fetch_pc, 32'h4);
    decode_step = 3'd0; #1;
    check("step_err_off", 32'(step_err), 32'd0);
    tick();
    check("plus0_hold", fetch_pc, 32'h4);

    // reset while a redirect is pending
    stall = 1'b1; decode_step = 3'd2;
    redir(2'b01, 32'h5000, 32'h0);
    tick(); no_redir();
    check("pre_rst_pending", 32'(redir_pending), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_pc",      fetch_pc,           START);
    check("mid_rst_pending", 32'(redir_pending), 32'd0);
    rst = 1'b0; stall = 1'b0;
    tick(); check("after_rst_pc0", fetch_pc, 32'h100);
    tick(); check("after_rst_pc1", fetch_pc, 32'h104);
    tick(); check("after_rst_pc2", fetch_pc, 32'h108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
